// File: rtl/aes_vector_sequencer.sv
// aes_vector_sequencer: walks a table of (plaintext, key, expected) vectors through
// AES_top, checks each result against the expected ciphertext, and keeps
// pass/fail/timeout statistics. Supports single-pass and continuous loop operation.
module aes_vector_sequencer #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              start,
    input  logic              loop_mode,
    input  logic              abort,
    output logic [IDX_W-1:0]  vec_idx,
    input  logic [DATA_W-1:0] vec_data,
    input  logic [DATA_W-1:0] vec_key,
    input  logic [DATA_W-1:0] vec_expect,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [DATA_W-1:0] AES_key_in,
    input  logic [DATA_W-1:0] AES_data_out,
    input  logic              AES_data_out_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic              first_fail_vld,
    output logic [IDX_W-1:0]  first_fail_idx
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_N  = (GAP > 0) ? GAP : 1;
    localparam int unsigned GAP_W  = (GAP_N > 1) ? $clog2(GAP_N) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [DATA_W-1:0]   expect_q;
    logic [DATA_W-1:0]   result_q;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Sequencer FSM with all outputs registered; reset beats abort beats everything else.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            expect_q       <= '0;
            result_q       <= '0;
            vec_idx        <= '0;
            AES_en         <= 1'b0;
            AES_data_in    <= '0;
            AES_key_in     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            timeout_cnt    <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (abort) begin
            state  <= S_IDLE;
            AES_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        timeout_cnt    <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        vec_idx        <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        state          <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    AES_data_in <= vec_data;
                    AES_key_in  <= vec_key;
                    expect_q    <= vec_expect;
                    wait_cnt    <= '0;
                    AES_en      <= 1'b1;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (AES_data_out_valid) begin
                        result_q <= AES_data_out;
                        AES_en   <= 1'b0;
                        state    <= S_CHECK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fail_cnt    <= sat_inc(fail_cnt);
                        timeout_cnt <= sat_inc(timeout_cnt);
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= vec_idx;
                        end
                        AES_en  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_CHECK: begin
                    if (result_q == expect_q) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end else begin
                        fail_cnt <= sat_inc(fail_cnt);
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= vec_idx;
                        end
                    end
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (vec_idx != LAST_IDX) begin
                            vec_idx <= vec_idx + 1'b1;
                            state   <= S_LOAD;
                        end else if (loop_mode) begin
                            vec_idx <= '0;
                            state   <= S_LOAD;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    AES_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Self-checking bench for aes_vector_sequencer: a table ROM, a latency-programmable
// AES stand-in, and a per-pass reference model of counts, order and timing.
`timescale 1ns/1ps
module tb_aes_vector_sequencer;

    localparam int DATA_W  = 128;
    localparam int NUM_VEC = 4;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;
    localparam int CNT_W   = 16;
    localparam int IDX_W   = 2;
    localparam int GAP_N   = (GAP > 0) ? GAP : 1;

    logic              AES_clk = 1'b0;
    logic              AES_rst;
    logic              start;
    logic              loop_mode;
    logic              abort;
    logic [IDX_W-1:0]  vec_idx;
    logic [DATA_W-1:0] vec_data;
    logic [DATA_W-1:0] vec_key;
    logic [DATA_W-1:0] vec_expect;
    logic              AES_en;
    logic [DATA_W-1:0] AES_data_in;
    logic [DATA_W-1:0] AES_key_in;
    logic [DATA_W-1:0] AES_data_out;
    logic              AES_data_out_valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic [CNT_W-1:0]  timeout_cnt;
    logic              first_fail_vld;
    logic [IDX_W-1:0]  first_fail_idx;

    int checks = 0;
    int errors = 0;

    // Vector table: tbl_ct is what the AES stand-in returns, tbl_exp is what the ROM claims.
    logic [DATA_W-1:0] tbl_pt  [NUM_VEC];
    logic [DATA_W-1:0] tbl_key [NUM_VEC];
    logic [DATA_W-1:0] tbl_ct  [NUM_VEC];
    logic [DATA_W-1:0] tbl_exp [NUM_VEC];
    int                lat     [NUM_VEC];   // 0 = never responds
    int                en_cnt = 0;

    aes_vector_sequencer #(
        .DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT), .GAP(GAP), .CNT_W(CNT_W)
    ) dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst), .start(start), .loop_mode(loop_mode),
        .abort(abort), .vec_idx(vec_idx), .vec_data(vec_data), .vec_key(vec_key),
        .vec_expect(vec_expect), .AES_en(AES_en), .AES_data_in(AES_data_in),
        .AES_key_in(AES_key_in), .AES_data_out(AES_data_out),
        .AES_data_out_valid(AES_data_out_valid), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
    );

    always #5 AES_clk = ~AES_clk;

    // Combinational ROM.
    assign vec_data   = tbl_pt[vec_idx];
    assign vec_key    = tbl_key[vec_idx];
    assign vec_expect = tbl_exp[vec_idx];

    // AES stand-in: counts enabled cycles, answers on the lat-th one.
    always @(posedge AES_clk) en_cnt <= AES_en ? en_cnt + 1 : 0;

    always_comb begin
        AES_data_out_valid = 1'b0;
        AES_data_out       = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (AES_en && tbl_pt[i] === AES_data_in && tbl_key[i] === AES_key_in) begin
                AES_data_out       = tbl_ct[i];
                AES_data_out_valid = (lat[i] != 0) && (en_cnt == lat[i] - 1);
            end
        end
    end

    // Monitor: index at each RUN entry, length of each AES_en burst, any done.
    int idx_q[$];
    int len_q[$];
    int run_len   = 0;
    bit en_prev   = 1'b0;
    bit done_seen = 1'b0;

    always @(negedge AES_clk) begin
        if (AES_en && !en_prev) idx_q.push_back(int'(vec_idx));
        if (AES_en) run_len++;
        else if (en_prev) begin
            len_q.push_back(run_len);
            run_len = 0;
        end
        if (done) done_seen = 1'b1;
        en_prev = AES_en;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge AES_clk);
        #1;
    endtask

    task automatic clear_mon();
        idx_q.delete();
        len_q.delete();
        run_len   = 0;
        done_seen = 1'b0;
    endtask

    task automatic rand_tables();
        for (int i = 0; i < NUM_VEC; i++) begin
            tbl_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
            tbl_key[i] = {$urandom, $urandom, $urandom, $urandom};
            tbl_ct[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        tbl_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        tbl_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        tbl_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        for (int i = 0; i < NUM_VEC; i++) tbl_exp[i] = tbl_ct[i];
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_en"},     AES_en, 0);
        check({tag, "_din"},    AES_data_in, 0);
        check({tag, "_kin"},    AES_key_in, 0);
        check({tag, "_idx"},    vec_idx, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_pass"},   pass_cnt, 0);
        check({tag, "_fail"},   fail_cnt, 0);
        check({tag, "_tmo"},    timeout_cnt, 0);
        check({tag, "_ffvld"},  first_fail_vld, 0);
        check({tag, "_ffidx"},  first_fail_idx, 0);
    endtask

    // Pulse start, then confirm LOAD one cycle later and RUN with vector 0 the cycle after.
    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_load_en"},   AES_en, 0);
        check({tag, "_load_busy"}, busy, 1);
        check({tag, "_load_done"}, done, 0);
        tick();
        check({tag, "_run_en"},  AES_en, 1);
        check({tag, "_run_din"}, AES_data_in, tbl_pt[0]);
        check({tag, "_run_kin"}, AES_key_in, tbl_key[0]);
    endtask

    // One non-looping pass, checked against totals derived from the table and latencies.
    task automatic run_pass(input string tag);
        int ep = 0, ef = 0, et = 0, ffi = 0, cyc = 0, n;
        bit ffv = 1'b0;
        int exp_len[NUM_VEC];
        for (int i = 0; i < NUM_VEC; i++) begin
            bit timed_out;
            timed_out  = (lat[i] == 0) || (lat[i] > TIMEOUT);
            exp_len[i] = timed_out ? TIMEOUT : lat[i];
            cyc += 1 + exp_len[i] + (timed_out ? 0 : 1) + GAP_N;
            if (timed_out) begin
                ef++; et++;
                if (!ffv) begin ffv = 1'b1; ffi = i; end
            end else if (tbl_ct[i] === tbl_exp[i]) begin
                ep++;
            end else begin
                ef++;
                if (!ffv) begin ffv = 1'b1; ffi = i; end
            end
        end
        clear_mon();
        do_start(tag);
        n = 1;
        while (done !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_done"},   done, 1);
        check({tag, "_cycles"}, n, cyc);
        check({tag, "_pass"},   pass_cnt, ep);
        check({tag, "_fail"},   fail_cnt, ef);
        check({tag, "_tmo"},    timeout_cnt, et);
        check({tag, "_ffvld"},  first_fail_vld, ffv);
        if (ffv) check({tag, "_ffidx"}, first_fail_idx, ffi);
        check({tag, "_nvec"}, idx_q.size(), NUM_VEC);
        for (int i = 0; i < NUM_VEC && i < idx_q.size() && i < len_q.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), idx_q[i], i);
            check($sformatf("%s_enlen%0d", tag, i), len_q[i], exp_len[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        AES_rst   = 1'b1;
        start     = 1'b0;
        loop_mode = 1'b0;
        abort     = 1'b0;
        rand_tables();
        for (int i = 0; i < NUM_VEC; i++) lat[i] = 11;
        repeat (3) tick();
        AES_rst = 1'b0;
        tick();
        check_reset_values("reset");

        // All vectors pass with an 11-cycle AES latency.
        run_pass("allpass");

        // Entry 2 expected value corrupted in bit 0.
        rand_tables();
        for (int i = 0; i < NUM_VEC; i++) lat[i] = int'($urandom_range(1, 20));
        tbl_exp[2][0] = ~tbl_exp[2][0];
        run_pass("mismatch");

        // Entry 1 never answers.
        rand_tables();
        for (int i = 0; i < NUM_VEC; i++) lat[i] = int'($urandom_range(1, 20));
        lat[1] = 0;
        run_pass("timeout");

        // Entry 3 answers exactly on the last allowed RUN cycle.
        rand_tables();
        for (int i = 0; i < NUM_VEC; i++) lat[i] = 11;
        lat[3] = TIMEOUT;
        run_pass("edge");

        // Loop mode for three full passes, then abort during the 13th RUN.
        rand_tables();
        for (int i = 0; i < NUM_VEC; i++) lat[i] = int'($urandom_range(1, 10));
        loop_mode = 1'b1;
        clear_mon();
        do_start("loop");
        n = 0;
        while (idx_q.size() < 3 * NUM_VEC + 1 && n < 3000) begin
            tick();
            n++;
        end
        check("loop_reached", idx_q.size(), 3 * NUM_VEC + 1);
        check("loop_pass", pass_cnt, 3 * NUM_VEC);
        check("loop_fail", fail_cnt, 0);
        check("loop_nodone", done_seen, 0);
        for (int i = 0; i < idx_q.size() && i <= 3 * NUM_VEC; i++)
            check($sformatf("loop_idx%0d", i), idx_q[i], i % NUM_VEC);
        check("abort_pre_en", AES_en, 1);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        loop_mode = 1'b0;
        check("abort_en",   AES_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass_cnt, 3 * NUM_VEC);
        repeat (4) tick();
        check("abort_idle_en",   AES_en, 0);
        check("abort_idle_busy", busy, 0);
        check("abort_hold_pass", pass_cnt, 3 * NUM_VEC);

        // Reset in the middle of RUN, then a clean restart.
        rand_tables();
        for (int i = 0; i < NUM_VEC; i++) lat[i] = 11;
        tbl_exp[0][0] = ~tbl_exp[0][0];
        clear_mon();
        do_start("rstrun");
        repeat (4) tick();
        check("rstrun_en", AES_en, 1);
        AES_rst = 1'b1;
        tick();
        check_reset_values("midreset");
        AES_rst = 1'b0;
        tick();
        tbl_exp[0] = tbl_ct[0];
        run_pass("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_vector_sequencer.md
# aes_vector_sequencer

Parametrised, synthesizable stimulus/check sequencer for `AES_top`. It walks a table of NUM_VEC (plaintext, key, expected-ciphertext) vectors. For each vector it:
- drives `AES_en`, `AES_data_in` and `AES_key_in`;
- waits for `AES_data_out_valid`, bounded by a timeout;
- compares `AES_data_out` against the expected value.

It keeps pass/fail/timeout statistics and can loop continuously. It sits between an external vector ROM and `AES_top`, and replaces hand-timed stimulus for on-chip and regression self-test.

## Interface
- `DATA_W`, 128: width of data, key and expected vectors.
- `NUM_VEC`, 4: number of table entries (≥1).
- `TIMEOUT`, 64: maximum RUN cycles waiting for valid (≥1).
- `GAP`, 2: idle cycles between vectors, `AES_en`=0 (≥0).
- `CNT_W`, 16: statistics counter width.
- `IDX_W`, derived: `$clog2(NUM_VEC)`, minimum 1.

- `AES_clk` in 1: single clock, rising edge.
- `AES_rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a pass. Sampled in IDLE/DONE.
- `loop_mode` in 1: 1 = wrap to vector 0 after the last vector instead of going to DONE. Sampled in GAP.
- `abort` in 1: return to IDLE next cycle from any state. Counters are held.
- `vec_idx` out IDX_W: ROM address (current index register).
- `vec_data` in DATA_W: ROM plaintext.
- `vec_key` in DATA_W: ROM key.
- `vec_expect` in DATA_W: ROM expected ciphertext.
- `AES_en` out 1: enable to `AES_top`.
- `AES_data_in` out DATA_W: registered plaintext to `AES_top`.
- `AES_key_in` out DATA_W: registered key to `AES_top`.
- `AES_data_out` in DATA_W: `AES_top` result.
- `AES_data_out_valid` in 1: `AES_top` result valid.
- `busy` out 1: state ≠ IDLE/DONE.
- `done` out 1: high in DONE.
- `pass_cnt` out CNT_W: matching vectors.
- `fail_cnt` out CNT_W: mismatching plus timed-out vectors.
- `timeout_cnt` out CNT_W: timed-out vectors only.
- `first_fail_vld` out 1: a failure has been recorded this pass.
- `first_fail_idx` out IDX_W: index of the first failure.

## Operation
- States: IDLE, LOAD, RUN, CHECK, GAP, DONE.
- **IDLE / DONE**: when `start`=1, clear all counters, `first_fail_vld` and the index, then go to LOAD.
- **LOAD** (1 cycle): register `vec_data` into `AES_data_in`, `vec_key` into `AES_key_in`, and `vec_expect` internally. Clear the wait counter. Go to RUN.
- **RUN**:
  - `AES_en`=1 and the wait counter increments each cycle.
  - `AES_data_out_valid`=1: capture `AES_data_out` and go to CHECK.
  - Otherwise, when the wait counter reaches TIMEOUT: fail and timeout increment, record the first failure, go to GAP.
  - Valid in the same cycle the timeout is reached: valid wins.
- **CHECK** (1 cycle):
  - `AES_en`=0.
  - Captured output == expected: `pass_cnt`+1.
  - Otherwise: `fail_cnt`+1, and if `first_fail_vld`=0, set it and latch the index.
  - Go to GAP.
- **GAP**:
  - GAP cycles with `AES_en`=0; with GAP=0, exit after 1 cycle.
  - Not the last index: index+1, go to LOAD.
  - Last index and `loop_mode`=1: index=0, go to LOAD. Counters keep accumulating.
  - Last index and `loop_mode`=0: go to DONE.
- Valid outside RUN is ignored.
- All counters saturate at 2^CNT_W−1.
- `abort` has priority over every other transition. It deasserts `AES_en` next cycle.

## Timing
- Reset values: state IDLE; `AES_en`=0; `AES_data_in`=0; `AES_key_in`=0; `vec_idx`=0; `busy`=0; `done`=0; all counters 0; `first_fail_vld`=0; `first_fail_idx`=0.
- ROM read is combinational: `vec_*` must be valid in the same cycle `vec_idx` is presented. It is sampled at the end of LOAD.
- `start` at cycle t gives LOAD at t+1 and `AES_en`=1 from t+2.
- `AES_data_in` and `AES_key_in` are stable for the whole of RUN.
- Counter updates are visible the cycle after CHECK, or the cycle after the timeout.
- Cycles per vector = 1 + (cycles to valid, ≤TIMEOUT) + 1 + max(GAP,1). A timed-out vector skips CHECK.
- `done` rises the cycle after the last GAP cycle.
- Reset mid-pass forces all reset values on the next edge, regardless of state.

## Test plan
- **Single pass, all pass.** Setup: NUM_VEC=4; the bench DUT model asserts valid 11 cycles after `AES_en` and returns the correct ciphertext. Entry 0 is the FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, ct 69c4e0d86a7b0430d8cdb78070b4c55a. Required: `pass_cnt`=4, `fail_cnt`=0, `done`=1, and `AES_en` high for exactly 11 cycles per vector.
- **Mismatch.** Stimulus: corrupt expected of entry 2 (bit 0 flipped). Required: `pass_cnt`=3, `fail_cnt`=1, `first_fail_vld`=1, `first_fail_idx`=2.
- **Timeout.** Stimulus: the DUT model never asserts valid for entry 1; TIMEOUT=64. Required: `AES_en` low after exactly 64 RUN cycles, `timeout_cnt`=1, `fail_cnt`=1, the sequence continues, and `done`=1.
- **Valid coinciding with timeout.** Stimulus: valid arrives exactly at the TIMEOUT cycle with correct data. Required: `pass_cnt` increments and `timeout_cnt` stays 0.
- **Loop mode.** Stimulus: `loop_mode`=1 for 3 full passes. Required: `vec_idx` goes 0,1,2,3,0,…; `pass_cnt`=12; `done` never asserts.
- **Abort and reset.** Stimulus: `abort` mid-RUN. Required: IDLE and `AES_en`=0 next cycle, with counters held. Then `AES_rst`=1 mid-RUN: all outputs at reset values next edge. Then `start`: a clean restart from index 0.
